// File: rtl/aes_serial_share_loader.sv
// Masking front-end for the byte-serial first-order masked AES core: shares pt/key, streams them
// in under core reset, collects ciphertext shares. Optional macro: SHARE_LOADER_ZEROMASK_EN.
module aes_serial_share_loader #(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         busy,
    output logic         ct_valid,
    output logic         err,
    output logic [127:0] ct1,
    output logic [127:0] ct2,
    output logic         c_rst,
    output logic [7:0]   c_r,
    output logic [7:0]   c_input1,
    output logic [7:0]   c_input2,
    output logic [7:0]   c_key1,
    output logic [7:0]   c_key2,
    input  logic [7:0]   c_output1,
    input  logic [7:0]   c_output2,
    input  logic         c_done
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StCollect, StDone} state_e;

    // An all-zero seed would lock the LFSR.
    localparam logic [31:0] SeedEff = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    state_e        state_q, state_d;
    logic [127:0]  pt_q, pt_d, key_q, key_d;
    logic [127:0]  ct1_q, ct1_d, ct2_q, ct2_d;
    logic [3:0]    k_q, k_d;
    logic [31:0]   run_cnt_q, run_cnt_d;
    logic          err_q, err_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [7:0]    m_p, m_k, m_r;
    logic [127:0]  pt_sel, key_sel;

    // x^32 + x^22 + x^2 + x + 1, 24 steps per cycle so bits [23:0] are all fresh.
    function automatic logic [31:0] lfsr_step24(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 24; i++) begin
            v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
        end
        return v;
    endfunction

    assign lfsr_d = lfsr_step24(lfsr_q);

`ifdef SHARE_LOADER_ZEROMASK_EN
    assign m_p = 8'h00;
    assign m_k = 8'h00;
    assign m_r = 8'h00;
`else
    assign m_p = lfsr_q[7:0];
    assign m_k = lfsr_q[15:8];
    assign m_r = lfsr_q[23:16];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pt_q      <= '0;
            key_q     <= '0;
            ct1_q     <= '0;
            ct2_q     <= '0;
            k_q       <= '0;
            run_cnt_q <= '0;
            err_q     <= 1'b0;
            lfsr_q    <= SeedEff;
        end else begin
            pt_q      <= pt_d;
            key_q     <= key_d;
            ct1_q     <= ct1_d;
            ct2_q     <= ct2_d;
            k_q       <= k_d;
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
            lfsr_q    <= lfsr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pt_d      = pt_q;
        key_d     = key_q;
        ct1_d     = ct1_q;
        ct2_d     = ct2_q;
        k_d       = k_q;
        run_cnt_d = run_cnt_q;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pt_d    = pt;
                    key_d   = key;
                    k_d     = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    run_cnt_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (c_done) begin
                    ct1_d   = {ct1_q[119:0], c_output1};
                    ct2_d   = {ct2_q[119:0], c_output2};
                    k_d     = 4'd1;
                    state_d = StCollect;
                end else if (run_cnt_q == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    run_cnt_d = run_cnt_q + 32'd1;
                end
            end
            StCollect: begin
                if (c_done) begin
                    ct1_d = {ct1_q[119:0], c_output1};
                    ct2_d = {ct2_q[119:0], c_output2};
                    k_d   = k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        state_d = StDone;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pt_sel   = pt_q << {k_q, 3'b000};
        key_sel  = key_q << {k_q, 3'b000};
        busy     = (state_q != StIdle);
        ct_valid = (state_q == StDone);
        c_rst    = rst | (state_q == StIdle) | (state_q == StLoad);
        // Randomness only matters once the core is running.
        c_r      = c_rst ? 8'h00 : m_r;
        c_input1 = 8'h00;
        c_input2 = 8'h00;
        c_key1   = 8'h00;
        c_key2   = 8'h00;
        if (state_q == StLoad) begin
            c_input1 = pt_sel[127:120] ^ m_p;
            c_input2 = m_p;
            c_key1   = key_sel[127:120] ^ m_k;
            c_key2   = m_k;
        end
    end

    assign err = err_q;
    assign ct1 = ct1_q;
    assign ct2 = ct2_q;

endmodule

// File: doc/aes_serial_share_loader.md
Name: aes_serial_share_loader

Overview:
- Front-end controller for the byte-serial first-order masked AES encryption core (`Cipher`).
- Accepts a 128-bit plaintext and key in unmasked form and splits every byte into two Boolean shares using an internal PRNG.
- Streams the 16 share pairs into the core while holding the core's reset, then releases it and supplies fresh 8-bit randomness every cycle.
- Collects the 16 ciphertext share bytes and presents them as two 128-bit shares with a one-cycle valid pulse.

Parameters:
- LFSR_SEED, 32'hACE1_2468, initial PRNG state loaded on rst; value 0 is replaced by 32'h1.
- TIMEOUT, 1023, maximum RUN cycles waiting for c_done before aborting; must be at least 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin encryption; sampled only in IDLE.
- pt  in  128  plaintext; pt[127:120] is byte 0.
- key  in  128  key; key[127:120] is byte 0.
- busy  out  1  high in every state except IDLE.
- ct_valid  out  1  one-cycle pulse; ct1/ct2 hold a complete result.
- err  out  1  one-cycle pulse on timeout abort.
- ct1, ct2  out  128  ciphertext shares; ct1^ct2 is the ciphertext, byte 0 in [127:120].
- c_rst  out  1  reset to the core.
- c_r  out  8  fresh randomness to the core.
- c_input1, c_input2  out  8  plaintext shares.
- c_key1, c_key2  out  8  key shares.
- c_output1, c_output2  in  8  ciphertext shares from the core.
- c_done  in  1  core result valid.

Behaviour:
- Core contract:
  - While c_rst=1, the core shifts in one share-pair byte per cycle; the last 16 bytes presented before c_rst falls are the state and key.
  - After completion, the core holds c_done=1 for 16 consecutive cycles and presents ciphertext share bytes 0..15 on c_output1/2, one per cycle, starting with the first c_done cycle.
- PRNG:
  - 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, unrolled by 24 steps per cycle.
  - Runs every cycle in every state. Bits [7:0] form mask m_p, [15:8] form m_k, [23:16] form c_r.
- Share outputs (combinational from the current LFSR state and counter):
  - c_input2=m_p, c_input1=pt_byte[k]^m_p.
  - c_key2=m_k, c_key1=key_byte[k]^m_k.
  - Outside LOAD, all four are driven to 0.
- c_rst = rst | (state==IDLE) | (state==LOAD). This is combinational, so the core is reset in the same cycle as rst.
- FSM:
  - IDLE: start=1 latches pt and key into internal registers, clears k, goes to LOAD.
  - LOAD: drives byte k; k increments each cycle; after k==15, goes to RUN with the run counter cleared.
  - RUN: c_rst=0. c_done=1 captures byte 0 and goes to COLLECT with k=1. If the run counter reaches TIMEOUT, err=1 for one cycle and the FSM goes to IDLE, with ct1/ct2 unchanged.
  - COLLECT: captures bytes on each cycle with c_done=1; after byte 15, goes to DONE. If c_done drops early, err pulses and the FSM returns to IDLE.
  - DONE: ct_valid=1 for exactly one cycle, then IDLE.
- Capture: ct1 and ct2 shift left by 8 and take c_output1/c_output2 in bits [7:0].
- Latency: start sampled at edge E0 gives LOAD in cycles 1..16 and RUN from cycle 17. ct_valid appears in the cycle after the 16th c_done cycle.
- Boundary conditions:
  - start in a non-IDLE state is ignored.
  - pt and key may change after the start edge.
  - start may be held high; a new run begins in the cycle after DONE.
- Reset mid-operation returns the FSM to IDLE in the next cycle and reloads LFSR_SEED.
- Reset values: busy=0, ct_valid=0, err=0, ct1=0, ct2=0, c_rst=1, c_r=0, all share outputs 0.

Optional Feature:
- Macro SHARE_LOADER_ZEROMASK_EN, a leakage-evaluation reference mode.
- Defined:
  - m_p, m_k and c_r are forced to 0, so c_input2=c_key2=c_r=0.
  - The LFSR is still present and still clocked.
- Undefined: the PRNG drives all masks and c_r as specified above.

Test Plan:
- FIPS-197 vector:
  - Stimulus: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Required: ct1^ct2=3925841d02dc09fbdc118597196a0b32 with one ct_valid pulse; busy drops in the next cycle.
- LOAD checker:
  - For every LOAD cycle k, c_input1^c_input2 equals pt byte k and c_key1^c_key2 equals key byte k; c_rst=1 for exactly 16 cycles before falling.
  - Across two runs with identical inputs, c_input2 must differ in at least one byte.
- Timeout: with a stub core that never raises c_done and TIMEOUT=20, err pulses 21 cycles after c_rst falls; busy=0 and ct_valid never asserts.
- Busy and back-to-back:
  - start pulsed during RUN has no effect.
  - start held high gives two consecutive correct encryptions, with IDLE lasting exactly one cycle between them.
- Reset mid-RUN:
  - rst asserted for one cycle mid-RUN: c_rst=1 in the same cycle, state returns to IDLE, and all outputs take their reset values.
  - A subsequent FIPS run is correct.
- With SHARE_LOADER_ZEROMASK_EN defined: c_input2, c_key2 and c_r are 0 throughout, and the FIPS vector still yields 3925841d02dc09fbdc118597196a0b32.
